// File: rtl/ioac_pkg.sv
// Shared constants for the ioac_seq ASCII operand to CPU instruction sequencer.
package ioac_pkg;

  localparam logic [7:0] OP_MOVE = 8'h01;
  localparam logic [7:0] OP_LOAD = 8'h02;
  localparam logic [7:0] OP_HEX  = 8'h12;

  typedef logic [2:0] state_t;
  localparam state_t StIdle    = 3'd0;
  localparam state_t StCollect = 3'd1;
  localparam state_t StDrain   = 3'd2;
  localparam state_t StEmit    = 3'd3;
  localparam state_t StDone    = 3'd4;

  localparam logic [5:0] PFX_MOVE = 6'h01;
  localparam logic [5:0] PFX_LO   = 6'h2C;
  localparam logic [5:0] PFX_HI   = 6'h2D;

  localparam logic [4:0] RT_BASE = 5'd16;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_BAD = 2'd1;
  localparam logic [1:0] ERR_OVF = 2'd2;

  // Returns {is_digit, value}; letters only count as digits in hex mode.
  function automatic logic [4:0] digit_val(input logic [7:0] c, input logic hex);
    digit_val = 5'h0;
    if (c >= 8'h30 && c <= 8'h39) begin
      digit_val = {1'b1, 4'(c - 8'h30)};
    end else if (hex && c >= 8'h41 && c <= 8'h46) begin
      digit_val = {1'b1, 4'(c - 8'h37)};
    end else if (hex && c >= 8'h61 && c <= 8'h66) begin
      digit_val = {1'b1, 4'(c - 8'h57)};
    end
  endfunction

endpackage

// File: rtl/ioac_ins_fifo.sv
// In-order instruction queue; pointers carry one extra wrap bit to tell full from empty.
module ioac_ins_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  // A full queue refuses the push even if the head leaves in the same cycle.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + PTR_ONE;
      if (w_do_pop)  r_rd <= r_rd + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  assign o_data = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/ioac_seq.sv
// Collects an ASCII operand, converts it and queues the matching CPU instructions.
// Define IOAC_SEQ_HEX_EN to enable the hex-load opcode 0x12.
module ioac_seq
  import ioac_pkg::*;
#(
  parameter int unsigned NUM_W      = 32,
  parameter int unsigned MAX_DIGITS = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IPP_W      = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [7:0]       Opcode,
  input  logic [IPP_W-1:0] IPP,
  input  logic [7:0]       InsPart,
  input  logic             PartValid,
  output logic             PartReady,
  output logic [31:0]      CPUIns,
  output logic             InsValid,
  input  logic             InsReady,
  output logic             Busy,
  output logic             Ready,
  output logic [1:0]       Error
);

  state_t           r_state, w_state_d;
  logic [7:0]       r_op, w_op_d;
  logic [4:0]       r_rt, w_rt_d;
  logic [NUM_W-1:0] r_acc, w_acc_d;
  logic [7:0]       r_cnt, w_cnt_d;
  logic [1:0]       r_err, w_err_d;
  logic             r_idx, w_idx_d;

  logic             w_op_ok;
  logic             w_hex;
  logic [7:0]       w_max;
  logic [7:0]       w_cnt_inc;
  logic [4:0]       w_dig;
  logic [NUM_W+4:0] w_acc_ext;
  logic [NUM_W+4:0] w_mac;
  logic [31:0]      w_val;
  logic [31:0]      w_ins;
  logic             w_last;
  logic             w_push;
  logic             w_full;
  logic             w_empty;

`ifdef IOAC_SEQ_HEX_EN
  assign w_op_ok = (Opcode == OP_MOVE) || (Opcode == OP_LOAD) || (Opcode == OP_HEX);
  assign w_hex   = (r_op == OP_HEX);
`else
  assign w_op_ok = (Opcode == OP_MOVE) || (Opcode == OP_LOAD);
  assign w_hex   = 1'b0;
`endif

  assign w_max     = w_hex ? 8'(NUM_W / 4) : 8'(MAX_DIGITS);
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_dig     = digit_val(InsPart, w_hex);
  // Five guard bits catch any carry out of acc*16+15 or acc*10+9.
  assign w_acc_ext = {5'b0, r_acc};
  assign w_mac     = (w_hex ? (w_acc_ext << 4) : ((w_acc_ext << 3) + (w_acc_ext << 1)))
                   + {{(NUM_W + 1){1'b0}}, w_dig[3:0]};

  always_comb begin
    w_state_d = r_state;
    w_op_d    = r_op;
    w_rt_d    = r_rt;
    w_acc_d   = r_acc;
    w_cnt_d   = r_cnt;
    w_err_d   = r_err;
    w_idx_d   = r_idx;
    unique case (r_state)
      StIdle: begin
        if (Start) begin
          w_op_d  = Opcode;
          w_rt_d  = RT_BASE + 5'(IPP);
          w_acc_d = '0;
          w_cnt_d = '0;
          w_idx_d = 1'b0;
          if (w_op_ok) begin
            w_err_d   = ERR_OK;
            w_state_d = StCollect;
          end else begin
            w_err_d   = ERR_BAD;
            w_state_d = StDrain;
          end
        end
      end
      StCollect: begin
        if (PartValid) begin
          if (InsPart == 8'h00) begin
            w_state_d = StEmit;
          end else if (!w_dig[4]) begin
            w_err_d   = ERR_BAD;
            w_state_d = StDrain;
          end else if ((w_mac[NUM_W+4:NUM_W] != '0) || (w_cnt_inc > w_max)) begin
            w_err_d   = ERR_OVF;
            w_state_d = StDrain;
          end else begin
            w_acc_d = w_mac[NUM_W-1:0];
            w_cnt_d = w_cnt_inc;
          end
        end
      end
      StDrain: begin
        if (PartValid && InsPart == 8'h00) w_state_d = StDone;
      end
      StEmit: begin
        if (!w_full) begin
          if (w_last) w_state_d = StDone;
          else        w_idx_d   = 1'b1;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= StIdle;
      r_op    <= '0;
      r_rt    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_err   <= ERR_OK;
      r_idx   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_op    <= w_op_d;
      r_rt    <= w_rt_d;
      r_acc   <= w_acc_d;
      r_cnt   <= w_cnt_d;
      r_err   <= w_err_d;
      r_idx   <= w_idx_d;
    end
  end

  assign w_val  = 32'(r_acc);
  assign w_last = (r_op == OP_MOVE) || r_idx;

  always_comb begin
    if (r_op == OP_MOVE) begin
      w_ins = {PFX_MOVE, r_rt, 5'h0, w_val[4:0], 11'h0};
    end else if (!r_idx) begin
      w_ins = {PFX_LO, r_rt, 5'h0, w_val[15:0]};
    end else begin
      w_ins = {PFX_HI, r_rt, 5'h0, w_val[31:16]};
    end
  end

  assign w_push = (r_state == StEmit);

  ioac_ins_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_push  (w_push),
    .i_data  (w_ins),
    .i_pop   (InsReady),
    .o_data  (CPUIns),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign InsValid  = !w_empty;
  assign PartReady = (r_state == StCollect) || (r_state == StDrain);
  assign Busy      = (r_state != StIdle);
  assign Ready     = (r_state == StDone);
  assign Error     = r_err;

endmodule
